// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the sequential shift-add multiplier.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between the pipeline core (master) and the multiplier (slave).
interface seq_multiplier_if;
    import mult_pkg::*;

    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   s;
    logic                 mult_active;

    modport master (
        output start, is_signed, a, b,
        input  s, mult_active
    );

    modport slave (
        input  start, is_signed, a, b,
        output s, mult_active
    );

endinterface

// File: rtl/seq_multiplier.sv
// Multi-cycle WIDTHxWIDTH -> 2*WIDTH shift-add multiplier, one multiplier bit per clock.
// Optional MULT_SIGNED_EN adds two's-complement support (magnitude multiply + final negate).
module seq_multiplier
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    seq_multiplier_if.slave  bus
);

`ifdef MULT_SIGNED_EN
    // |v| as an unsigned magnitude; the most negative value maps onto 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] neg_v;
        neg_v = -v;
        return v[WIDTH-1] ? WIDTH'(neg_v) : WIDTH'(v);
    endfunction
`endif

    state_e               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplr_q,   mplr_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   s_q,      s_d;
    logic                 active_q, active_d;
    logic [WIDTH:0]       sum;

`ifdef MULT_SIGNED_EN
    logic                 neg_q,    neg_d;
`else
    logic                 unused_is_signed;
    assign unused_is_signed = bus.is_signed;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        s_d     = s_q;
`ifdef MULT_SIGNED_EN
        neg_d   = neg_q;
`endif
        // Upper half of the accumulator plus the multiplicand, carry kept in bit WIDTH.
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef MULT_SIGNED_EN
                    if (bus.is_signed) begin
                        mcand_d = magnitude(bus.a);
                        mplr_d  = magnitude(bus.b);
                        neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end else begin
                        mcand_d = bus.a;
                        mplr_d  = bus.b;
                        neg_d   = 1'b0;
                    end
`else
                    mcand_d = bus.a;
                    mplr_d  = bus.b;
`endif
                end
            end
            RUN: begin
                acc_d  = {sum, acc_q[WIDTH-1:1]};
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
`ifdef MULT_SIGNED_EN
                s_d = neg_q ? -acc_q : acc_q;
`else
                s_d = acc_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            s_q      <= '0;
            active_q <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            s_q      <= s_d;
            active_q <= active_d;
`ifdef MULT_SIGNED_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign bus.s           = s_q;
    assign bus.mult_active = active_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (MULT_SIGNED_EN selects signed expectations).
module tb_seq_multiplier;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    seq_multiplier_if bus ();

    seq_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for mult_active to drop; n = number of sampled active cycles.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (bus.mult_active === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_timeout"}, 64'(n), 64'd33);
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sg, input logic [63:0] exp);
        int n;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.is_signed = sg; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tag, n);
        chk(tag, bus.s, exp);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(negedge clk);
        chk("reset_s", bus.s, 64'h0);
        chk("reset_active", {63'h0, bus.mult_active}, 64'h0);
        reset = 1'b0;

        // Unsigned vectors, with active-length measurement on the first.
        @(negedge clk);
        bus.a = 32'd6; bus.b = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("u_6x3", n);
        chk("active_cycles", 64'(n), 64'd33);
        chk("u_6x3", bus.s, 64'h0000_0000_0000_0012);
        do_mult("u_6xm3", 32'd6, 32'hFFFF_FFFD, 1'b0, 64'h0000_0005_FFFF_FFEE);
        do_mult("u_m6x3", 32'hFFFF_FFFA, 32'd3, 1'b0, 64'h0000_0002_FFFF_FFEE);
        do_mult("u_m6xm3", 32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b0, 64'hFFFF_FFF7_0000_0012);

`ifdef MULT_SIGNED_EN
        do_mult("s_6x3", 32'd6, 32'd3, 1'b1, 64'h0000_0000_0000_0012);
        do_mult("s_6xm3", 32'd6, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEE);
        do_mult("s_m6x3", 32'hFFFF_FFFA, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFEE);
        do_mult("s_m6xm3", 32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b1, 64'h0000_0000_0000_0012);
        do_mult("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
`else
        // is_signed is ignored: products are the unsigned ones.
        do_mult("s_6x3", 32'd6, 32'd3, 1'b1, 64'h0000_0000_0000_0012);
        do_mult("s_6xm3", 32'd6, 32'hFFFF_FFFD, 1'b1, 64'h0000_0005_FFFF_FFEE);
        do_mult("s_m6x3", 32'hFFFF_FFFA, 32'd3, 1'b1, 64'h0000_0002_FFFF_FFEE);
        do_mult("s_m6xm3", 32'hFFFF_FFFA, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFF7_0000_0012);
        do_mult("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
`endif

        // Start pulsed mid-operation with new operands must be ignored.
        @(negedge clk);
        bus.a = 32'd6; bus.b = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.a = 32'd7; bus.b = 32'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 32'd11; bus.b = 32'd13;
        n = 6;
        while (bus.mult_active === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hs_active_cycles", 64'(n), 64'd33);
        chk("hs_result", bus.s, 64'h0000_0000_0000_0012);
        repeat (2) @(negedge clk);
        chk("hs_idle", {63'h0, bus.mult_active}, 64'h0);

        // Reset 10 cycles into an operation aborts it and clears s.
        @(negedge clk);
        bus.a = 32'hFFFF_FFFA; bus.b = 32'hFFFF_FFFD; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_active", {63'h0, bus.mult_active}, 64'h0);
        chk("rst_mid_s", bus.s, 64'h0);
        do_mult("post_rst", 32'd6, 32'hFFFF_FFFD, 1'b0, 64'h0000_0005_FFFF_FFEE);

        // Start held high: a new operation begins on the first idle edge.
        @(negedge clk);
        bus.a = 32'd6; bus.b = 32'd3; bus.is_signed = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        wait_done("b2b_1", n);
        chk("b2b_1", bus.s, 64'h0000_0000_0000_0012);
        bus.a = 32'hFFFF_FFFA; bus.b = 32'd3;
        @(negedge clk);
        chk("b2b_restart", {63'h0, bus.mult_active}, 64'h1);
        chk("b2b_hold", bus.s, 64'h0000_0000_0000_0012);
        wait_done("b2b_2", n);
        bus.start = 1'b0;
        chk("b2b_2", bus.s, 64'h0000_0002_FFFF_FFEE);
        chk("b2b_2_cycles", 64'(n), 64'd33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
